// File: rtl/npu_layer_sequencer_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
// npu_layer_sequencer_pkg - shared widths, layer entry type, FSM state. Rev 1.0
//----------------------------------------------------------------------------
package npu_layer_sequencer_pkg;

  localparam int W           = 8;
  localparam int K           = 3;
  localparam int C1_NB_TILE  = 3;
  localparam int C1_NB_TILEB = 2;
  localparam int C1_NB_TILEC = 2;
  localparam int C2_NB_TILE  = 2;
  localparam int C2_NB_TILEB = 3;
  localparam int C2_NB_TILEC = 1;

  localparam int CLOG2W = $clog2(W);
  localparam int CLOG2K = $clog2(K);
  // tile/ifmap/ofmap fields hold arv values up to 3
  localparam int CLOG2T = 2;
  localparam int CLOG2B = 2;
  localparam int CLOG2C = 2;

  localparam int NB_LAYERS_DEF = 4;
  localparam int CLOG2L        = $clog2(NB_LAYERS_DEF);

  typedef struct packed {
    logic [CLOG2K-1:0] ksize;
    logic [CLOG2W-1:0] ckgate;
    logic [CLOG2T-1:0] tile;
    logic [CLOG2B-1:0] ifmaps;
    logic [CLOG2C-1:0] ofmaps;
  } layer_cfg_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } seq_state_t;

  localparam layer_cfg_t c_entry0 = '{
    ksize : CLOG2K'(K - 1),
    ckgate: CLOG2W'(W - K),
    tile  : CLOG2T'(C1_NB_TILE - 1),
    ifmaps: CLOG2B'(C1_NB_TILEB - 1),
    ofmaps: CLOG2C'(C1_NB_TILEC - 1)
  };

  localparam layer_cfg_t c_entry1 = '{
    ksize : CLOG2K'(K - 1),
    ckgate: CLOG2W'(1),
    tile  : CLOG2T'(C2_NB_TILE - 1),
    ifmaps: CLOG2B'(C2_NB_TILEB - 1),
    ofmaps: CLOG2C'(C2_NB_TILEC - 1)
  };

endpackage
`default_nettype wire

// File: rtl/npu_layer_sequencer_if.sv
`default_nettype none
//----------------------------------------------------------------------------
// npu_layer_sequencer_if - step handshake bus from sequencer to array. Rev 1.0
//----------------------------------------------------------------------------
interface npu_layer_sequencer_if #(
  parameter int CLOG2L = npu_layer_sequencer_pkg::CLOG2L
);
  import npu_layer_sequencer_pkg::*;

  logic              step_valid;
  logic              step_ready;
  logic [CLOG2L-1:0] step_layer;
  logic [CLOG2C-1:0] step_ofmap;
  logic [CLOG2B-1:0] step_ifmap;
  logic [CLOG2T-1:0] step_tile;
  logic              step_last;

  modport master (
    output step_valid, step_layer, step_ofmap, step_ifmap, step_tile, step_last,
    input  step_ready
  );

  modport slave (
    input  step_valid, step_layer, step_ofmap, step_ifmap, step_tile, step_last,
    output step_ready
  );

endinterface
`default_nettype wire

// File: rtl/npu_layer_sequencer_loop_cnt.sv
`default_nettype none
//----------------------------------------------------------------------------
// npu_loop_cnt - arv-limited loop counter with wrap flag and carry out. Rev 1.0
//----------------------------------------------------------------------------
module npu_loop_cnt
  import npu_layer_sequencer_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap,
  output logic             carry
);

  logic [WIDTH-1:0] r_cnt;

  assign cnt   = r_cnt;
  assign wrap  = (r_cnt == limit);
  assign carry = inc & wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/npu_layer_sequencer.sv
`default_nettype none
//----------------------------------------------------------------------------
// npu_layer_sequencer - layer config table and tile/ifmap/ofmap loop walker. Rev 1.0
//----------------------------------------------------------------------------
module npu_layer_sequencer
  import npu_layer_sequencer_pkg::*;
#(
  parameter  int NB_LAYERS = NB_LAYERS_DEF,
  localparam int CLOG2L    = $clog2(NB_LAYERS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CLOG2L-1:0] cfg_layer,
  input  logic [CLOG2K-1:0] cfg_ksize,
  input  logic [CLOG2W-1:0] cfg_ckgate,
  input  logic [CLOG2T-1:0] cfg_tile,
  input  logic [CLOG2B-1:0] cfg_ifmaps,
  input  logic [CLOG2C-1:0] cfg_ofmaps,
  input  logic [CLOG2L-1:0] nb_layers,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  npu_layer_sequencer_if.master step,
  output logic [CLOG2W-1:0] arv_npu,
  output logic [CLOG2K-1:0] arv_ksize,
  output logic [CLOG2W-1:0] arv_ckgate,
  output logic              done
);

  seq_state_t        r_state, w_next;
  layer_cfg_t        r_table [NB_LAYERS];
  layer_cfg_t        r_cfg;
  logic [CLOG2L-1:0] r_layer_idx, r_nb_layers, w_nb_clamped;
  logic              w_cfg_ok, w_valid, w_adv, w_clr, w_layer_end;
  logic [CLOG2T-1:0] w_tile;
  logic [CLOG2B-1:0] w_ifmap;
  logic [CLOG2C-1:0] w_ofmap;
  logic              w_tile_wrap, w_if_wrap, w_of_wrap;
  logic              w_tile_carry, w_if_carry;

  // Range checks only exist when the table does not fill the index space
  generate
    if ((1 << CLOG2L) == NB_LAYERS) begin : g_pow2
      assign w_cfg_ok     = 1'b1;
      assign w_nb_clamped = nb_layers;
    end else begin : g_npow2
      assign w_cfg_ok     = (int'(cfg_layer) < NB_LAYERS);
      assign w_nb_clamped = (int'(nb_layers) < NB_LAYERS) ? nb_layers
                                                          : CLOG2L'(NB_LAYERS - 1);
    end
  endgenerate

  assign w_valid = (r_state == S_RUN);
  assign w_adv   = w_valid & step.step_ready & ~abort;
  assign w_clr   = (r_state == S_LOAD) | (w_valid & abort);

  npu_loop_cnt #(.WIDTH(CLOG2T)) u_tile (
    .clk(clk), .rst_n(rst_n), .clr(w_clr), .inc(w_adv), .limit(r_cfg.tile),
    .cnt(w_tile), .wrap(w_tile_wrap), .carry(w_tile_carry)
  );

  npu_loop_cnt #(.WIDTH(CLOG2B)) u_ifmap (
    .clk(clk), .rst_n(rst_n), .clr(w_clr), .inc(w_tile_carry), .limit(r_cfg.ifmaps),
    .cnt(w_ifmap), .wrap(w_if_wrap), .carry(w_if_carry)
  );

  // Carry out of the outermost loop is exactly "last step accepted"
  npu_loop_cnt #(.WIDTH(CLOG2C)) u_ofmap (
    .clk(clk), .rst_n(rst_n), .clr(w_clr), .inc(w_if_carry), .limit(r_cfg.ofmaps),
    .cnt(w_ofmap), .wrap(w_of_wrap), .carry(w_layer_end)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: w_next = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort)
          w_next = S_IDLE;
        else if (w_layer_end)
          w_next = (r_layer_idx == r_nb_layers) ? S_DONE : S_LOAD;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_layer_idx <= '0;
      r_nb_layers <= '0;
      r_cfg       <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_nb_layers <= w_nb_clamped;
          r_layer_idx <= '0;
        end
        S_LOAD: r_cfg <= r_table[r_layer_idx];
        S_RUN:  if (w_layer_end && (r_layer_idx != r_nb_layers))
          r_layer_idx <= r_layer_idx + 1'b1;
        default: ;
      endcase
    end
  end

  // A write coinciding with start commits on the same edge, so LOAD sees it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB_LAYERS; i++) r_table[i] <= '0;
      r_table[0] <= c_entry0;
      r_table[1] <= c_entry1;
    end else if ((r_state == S_IDLE) && cfg_we && w_cfg_ok) begin
      r_table[cfg_layer] <= '{ksize: cfg_ksize, ckgate: cfg_ckgate, tile: cfg_tile,
                              ifmaps: cfg_ifmaps, ofmaps: cfg_ofmaps};
    end
  end

  assign busy            = (r_state != S_IDLE);
  assign done            = (r_state == S_DONE);
  assign step.step_valid = w_valid;
  assign step.step_layer = r_layer_idx;
  assign step.step_ofmap = w_ofmap;
  assign step.step_ifmap = w_ifmap;
  assign step.step_tile  = w_tile;
  assign step.step_last  = w_valid & w_tile_wrap & w_if_wrap & w_of_wrap;
  assign arv_npu         = CLOG2W'(W - 1);
  assign arv_ksize       = r_cfg.ksize;
  assign arv_ckgate      = r_cfg.ckgate;

endmodule
`default_nettype wire

// File: tb/tb_npu_layer_sequencer.sv
`default_nettype none
//----------------------------------------------------------------------------
// tb_npu_layer_sequencer - directed runs checked against a loop-order model. Rev 1.0
//----------------------------------------------------------------------------
module tb_npu_layer_sequencer;
  import npu_layer_sequencer_pkg::*;

  localparam int NL = NB_LAYERS_DEF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0, start = 1'b0, abort = 1'b0;
  logic [CLOG2L-1:0] cfg_layer = '0, nb_layers = '0;
  logic [CLOG2K-1:0] cfg_ksize = '0;
  logic [CLOG2W-1:0] cfg_ckgate = '0;
  logic [CLOG2T-1:0] cfg_tile = '0;
  logic [CLOG2B-1:0] cfg_ifmaps = '0;
  logic [CLOG2C-1:0] cfg_ofmaps = '0;
  logic              busy, done;
  logic [CLOG2W-1:0] arv_npu, arv_ckgate;
  logic [CLOG2K-1:0] arv_ksize;

  npu_layer_sequencer_if bus ();

  npu_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_layer(cfg_layer),
    .cfg_ksize(cfg_ksize), .cfg_ckgate(cfg_ckgate), .cfg_tile(cfg_tile),
    .cfg_ifmaps(cfg_ifmaps), .cfg_ofmaps(cfg_ofmaps), .nb_layers(nb_layers),
    .start(start), .abort(abort), .busy(busy), .step(bus), .arv_npu(arv_npu),
    .arv_ksize(arv_ksize), .arv_ckgate(arv_ckgate), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CLOG2L-1:0] layer;
    logic [CLOG2C-1:0] ofm;
    logic [CLOG2B-1:0] ifm;
    logic [CLOG2T-1:0] tile;
    logic              last;
    logic [CLOG2K-1:0] ks;
    logic [CLOG2W-1:0] ck;
  } step_t;

  layer_cfg_t m_tab [NL];
  step_t      exp_q [$];
  step_t      acc_log [$];
  int         n_pass = 0, n_chk = 0, done_cnt = 0, busy_cyc = 0;
  bit         rand_ready = 1'b0;
  logic       ready_fixed = 1'b1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_tab[i] = '0;
    m_tab[0] = '{ksize: CLOG2K'(K-1), ckgate: CLOG2W'(W-K), tile: CLOG2T'(C1_NB_TILE-1),
                 ifmaps: CLOG2B'(C1_NB_TILEB-1), ofmaps: CLOG2C'(C1_NB_TILEC-1)};
    m_tab[1] = '{ksize: CLOG2K'(K-1), ckgate: CLOG2W'(1), tile: CLOG2T'(C2_NB_TILE-1),
                 ifmaps: CLOG2B'(C2_NB_TILEB-1), ofmaps: CLOG2C'(C2_NB_TILEC-1)};
  endtask

  // Step s of a layer decomposes as mixed-radix digits (ofmap, ifmap, tile)
  task automatic build_expect(input int nb);
    exp_q.delete();
    for (int l = 0; l <= nb; l++) begin
      int nt, ni, no, n;
      nt = int'(m_tab[l].tile) + 1;
      ni = int'(m_tab[l].ifmaps) + 1;
      no = int'(m_tab[l].ofmaps) + 1;
      n  = nt * ni * no;
      for (int s = 0; s < n; s++) begin
        step_t e;
        e.layer = CLOG2L'(l);
        e.tile  = CLOG2T'(s % nt);
        e.ifm   = CLOG2B'((s / nt) % ni);
        e.ofm   = CLOG2C'(s / (nt * ni));
        e.last  = (s == n - 1);
        e.ks    = m_tab[l].ksize;
        e.ck    = m_tab[l].ckgate;
        exp_q.push_back(e);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    bus.step_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (busy) busy_cyc++;
      if (bus.step_valid) begin
        step_t o;
        o = '{layer: bus.step_layer, ofm: bus.step_ofmap, ifm: bus.step_ifmap,
              tile: bus.step_tile, last: bus.step_last, ks: arv_ksize, ck: arv_ckgate};
        if (exp_q.size() == 0) begin
          chk("unexpected_step", 1, 0);
        end else begin
          chk("step", o, exp_q[0]);
          if (bus.step_ready && !abort) begin
            acc_log.push_back(o);
            void'(exp_q.pop_front());
          end
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_all_steps", exp_q.size(), 0);
      end
      if (abort && busy && !done) exp_q.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int l, input layer_cfg_t c);
    cfg_layer  = CLOG2L'(l);
    cfg_ksize  = c.ksize;
    cfg_ckgate = c.ckgate;
    cfg_tile   = c.tile;
    cfg_ifmaps = c.ifmaps;
    cfg_ofmaps = c.ofmaps;
    cfg_we     = 1'b1;
  endtask

  task automatic do_start(input int nb);
    build_expect(nb);
    acc_log.delete();
    busy_cyc  = 0;
    nb_layers = CLOG2L'(nb);
    start     = 1'b1;
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_no_valid", bus.step_valid, 0);
    tick();
    chk("first_valid", bus.step_valid, 1);
  endtask

  task automatic wait_done(input int max_cyc, input int exp_steps, input int exp_busy);
    int d0, k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < max_cyc) begin
      tick();
      k++;
    end
    chk("done_seen", longint'(done_cnt != d0), 1);
    tick();
    tick();
    chk("done_once", done_cnt - d0, 1);
    chk("idle_after", busy, 0);
    chk("steps_total", acc_log.size(), exp_steps);
    if (exp_busy >= 0) chk("busy_cycles", busy_cyc, exp_busy);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e_pos [4];
    int d0, k;
    layer_cfg_t c;
    e_pos = '{0, 1, 100, 101};
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", bus.step_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_npu", arv_npu, 7);
    chk("rst_ksize", arv_ksize, 0);
    chk("rst_ckgate", arv_ckgate, 0);
    chk("rst_step", {bus.step_layer, bus.step_ofmap, bus.step_ifmap,
                     bus.step_tile, bus.step_last}, 0);
    rst_n = 1'b1;
    tick();

    // Default table, two layers: 12 + 6 steps, one bubble between them
    do_start(1);
    wait_done(200, 18, 21);
    chk("l0_ckgate", acc_log[0].ck, 5);
    chk("l0_ksize", acc_log[0].ks, 2);
    chk("l1_ckgate", acc_log[17].ck, 1);

    // Rewritten entry0: two tiles by two ofmaps
    c = '{ksize: 2'd1, ckgate: 3'd2, tile: 2'd1, ifmaps: 2'd0, ofmaps: 2'd1};
    set_cfg(0, c);
    m_tab[0] = c;
    tick();
    cfg_we = 1'b0;
    do_start(0);
    wait_done(100, 4, 6);
    for (int i = 0; i < 4; i++) begin
      chk("t2_pos", acc_log[i].ofm * 100 + acc_log[i].ifm * 10 + acc_log[i].tile, e_pos[i]);
      chk("t2_last", acc_log[i].last, longint'(i == 3));
    end

    // Random backpressure over all four layers: 4 + 6 + 1 + 1
    rand_ready = 1'b1;
    do_start(3);
    wait_done(400, 12, -1);
    rand_ready = 1'b0;

    // Table writes while running must be dropped
    do_start(0);
    set_cfg(0, '{ksize: 2'd0, ckgate: 3'd0, tile: 2'd3, ifmaps: 2'd3, ofmaps: 2'd3});
    tick();
    cfg_we = 1'b0;
    wait_done(100, 4, 6);
    do_start(0);
    wait_done(100, 4, 6);

    // Abort during layer1 with ready high on the same cycle
    do_start(1);
    k = 0;
    while (!(bus.step_valid && bus.step_layer == 1) && k < 100) begin
      tick();
      k++;
    end
    chk("reach_layer1", longint'(bus.step_valid && bus.step_layer == 1), 1);
    d0    = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", bus.step_valid, 0);
    chk("abort_idle", busy, 0);
    tick();
    tick();
    chk("abort_no_done", done_cnt - d0, 0);
    do_start(0);
    wait_done(100, 4, 6);

    // start and cfg_we together: LOAD must see the all-zero entry
    set_cfg(0, '0);
    m_tab[0] = '0;
    do_start(0);
    wait_done(100, 1, 3);
    chk("t6_last", acc_log[0].last, 1);

    // Async reset mid-run restores the default table
    do_start(1);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", bus.step_valid, 0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    do_start(1);
    wait_done(200, 18, 21);
    chk("arst_tab_ck", acc_log[0].ck, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/npu_layer_sequencer.md
Name: npu_layer_sequencer

Overview:
- Programmable per-layer configuration table and loop sequencer for the NPU array controller.
- Generalises the fixed two-layer parameter selection to NB_LAYERS layers with a writable table.
- Walks ofmap / ifmap / tile loops for each layer and issues one step per tile over a valid/ready handshake.
- All counts use the "already-rolled value" (arv) encoding: stored value = count-1.

Parameters:
- NB_LAYERS, 4, number of table entries (>=2)
- CLOG2L, $clog2(NB_LAYERS), layer index width
- CLOG2W/CLOG2K/CLOG2T/CLOG2B/CLOG2C, from globals_sv, field widths for npu/ksize/ckgate/tile/ifmaps/ofmaps

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  table write strobe
- cfg_layer  in  CLOG2L  entry written
- cfg_ksize  in  CLOG2K  arv kernel size
- cfg_ckgate  in  CLOG2W  arv clock-gate column count
- cfg_tile  in  CLOG2T  arv tiles per ifmap
- cfg_ifmaps  in  CLOG2B  arv input fmaps
- cfg_ofmaps  in  CLOG2C  arv output fmaps
- nb_layers  in  CLOG2L  arv layers to run, sampled on start
- start  in  1  run request
- abort  in  1  synchronous abort
- busy  out  1  high when not IDLE
- step_valid  out  1  step offered
- step_ready  in  1  step accepted
- step_layer  out  CLOG2L  current layer
- step_ofmap  out  CLOG2C  current ofmap index
- step_ifmap  out  CLOG2B  current ifmap index
- step_tile  out  CLOG2T  current tile index
- step_last  out  1  final step of current layer
- arv_npu  out  CLOG2W  constant W-1
- arv_ksize  out  CLOG2K  latched layer ksize
- arv_ckgate  out  CLOG2W  latched layer ckgate
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: FSM=IDLE; all counters, step_*, arv_ksize, arv_ckgate, done, busy = 0; arv_npu = W-1.
- Table reset contents: entry0 = {K-1, W-K, C1_NB_TILE-1, C1_NB_TILEB-1, C1_NB_TILEC-1}; entry1 = {K-1, 1, C2_NB_TILE-1, C2_NB_TILEB-1, C2_NB_TILEC-1}; other entries all 0.
- cfg_we:
  - Committed at the clock edge only in IDLE; ignored in every other state.
  - cfg_layer values >= NB_LAYERS are ignored.
- States: IDLE, LOAD, RUN, DONE.
- IDLE -> LOAD on start; latch nb_layers and clear layer_idx.
  - start together with cfg_we in the same cycle: both are accepted, and LOAD reads the new value.
- LOAD (1 cycle):
  - Latch table[layer_idx] into working registers.
  - Drive arv_ksize/arv_ckgate from the latched entry.
  - Clear the ofmap/ifmap/tile counters; go to RUN.
- RUN:
  - step_valid=1. The step advances only on step_valid & step_ready.
  - Loop order: tile innermost, then ifmap, then ofmap.
  - When a counter equals its arv value it wraps to 0 and carries to the next loop.
  - step_last = (tile==arv_tile)&(ifmap==arv_ifmaps)&(ofmap==arv_ofmaps).
  - Accepted step with step_last: if layer_idx==nb_layers go to DONE, else increment layer_idx and go to LOAD. step_valid is 0 in LOAD.
  - Outputs are held stable while step_valid & !step_ready.
- DONE: done=1 for exactly 1 cycle, then IDLE. busy=0 only in IDLE.
- Latency: start at edge k -> LOAD in cycle k+1 -> first step_valid in cycle k+2. Each layer boundary inserts 1 bubble cycle.
- abort:
  - In LOAD/RUN: go to IDLE next edge, step_valid=0, no done pulse.
  - abort has priority over handshake advance in the same cycle.
  - Ignored in IDLE and DONE.
- start while busy is ignored.
- nb_layers >= NB_LAYERS is clamped to NB_LAYERS-1.
- Steps per layer = (tile+1)*(ifmaps+1)*(ofmaps+1). The all-zero entry gives exactly 1 step.
- Async reset mid-run returns to the reset state immediately. The table returns to its defaults.

Decomposition:
- globals_sv gets NB_LAYERS_DEF, CLOG2L, a packed struct layer_cfg_t {ksize, ckgate, tile, ifmaps, ofmaps}, and the state enum seq_state_t.
- Sub-module npu_loop_cnt: parameterised width, arv limit, inc/wrap/carry. Instantiated 3 times as a chained nest.

Test Plan:
- Reset, no writes, nb_layers=1, start, step_ready=1 -> layer0 yields C1_NB_TILE*C1_NB_TILEB*C1_NB_TILEC steps, then layer1 yields its C2 product; 1 bubble between layers; done pulses once; arv_ckgate = W-K then 1.
- Write entry2 {tile=1, ifmaps=0, ofmaps=1}, nb_layers=0 via entry swap (write it to entry0), start -> 4 steps (of,if,t) = (0,0,0),(0,0,1),(1,0,0),(1,0,1); step_last only on the 4th; first valid 2 cycles after start.
- Backpressure: toggle step_ready randomly -> step_* stable while stalled, no step dropped or duplicated, totals unchanged.
- cfg_we during RUN, then second run -> first run unaffected; the table still holds the old value.
- abort during layer1 with step_ready=1 in the same cycle -> step_valid low the next cycle, FSM in IDLE, no done pulse, counters cleared on the next start.
- start+cfg_we in the same IDLE cycle to entry0 with tile=0, ifmaps=0, ofmaps=0, nb_layers=0 -> exactly 1 step with step_last=1, then done.
